// File: rtl/seven_seg_pkg.sv
// Shared constants and hex decode table for the two-digit seven-segment driver.
// Segment vectors are active-low: a 0 bit lights the segment.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Bit positions inside the segment vector
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_mux_driver_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_mux_driver.sv
// Two-digit time-multiplexed seven-segment driver with a double-buffered value.
// New values are only committed at a frame boundary so a frame never tears.
module seven_seg_mux_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_value,
  input  logic       i_load,
  input  logic       i_blank_lz,
  input  logic       i_enable,
  output logic [6:0] o_digitalTube,
  output logic       o_sel,
  output logic       o_pending,
  output logic       o_frame_tick
);

  localparam int unsigned DIV = CLK_HZ / REFRESH_HZ;
  localparam int CW = (DIV >= 2) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2) begin : g_div_check
      $error("seven_seg_mux_driver: CLK_HZ/REFRESH_HZ must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic [7:0]    display;
  logic [7:0]    pend_val;
  logic          tick;
  logic          boundary;
  logic          sel_nxt;
  logic [7:0]    disp_nxt;
  logic [3:0]    nibble_nxt;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_nxt;

  assign tick     = (cnt == CW'(DIV - 1));
  assign boundary = tick & o_sel;

  // Segments are computed from the post-edge sel and display so the
  // digit switch and the new pattern land on the same edge.
  always_comb begin
    sel_nxt  = tick ? ~o_sel : o_sel;
    disp_nxt = display;
    if (boundary) begin
      if (i_load) begin
        disp_nxt = i_value;
      end else if (o_pending) begin
        disp_nxt = pend_val;
      end
    end
    nibble_nxt = sel_nxt ? disp_nxt[7:4] : disp_nxt[3:0];
  end

  hex_to_7seg u_dec (
    .nibble (nibble_nxt),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_nxt = dec_seg;
    if (!i_enable) begin
      seg_nxt = SEG_OFF;
    end else if (sel_nxt && i_blank_lz && (disp_nxt[7:4] == 4'h0)) begin
      seg_nxt = SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      o_sel         <= 1'b0;
      display       <= 8'h00;
      pend_val      <= 8'h00;
      o_pending     <= 1'b0;
      o_frame_tick  <= 1'b0;
      o_digitalTube <= SEG_OFF;
    end else begin
      cnt           <= tick ? '0 : cnt + CW'(1);
      o_sel         <= sel_nxt;
      display       <= disp_nxt;
      o_frame_tick  <= boundary;
      o_digitalTube <= seg_nxt;
      if (boundary) begin
        o_pending <= 1'b0;
      end else if (i_load) begin
        pend_val  <= i_value;
        o_pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seven_seg_mux_driver.md
Name: seven_seg_mux_driver

Overview:
- Time-multiplexed driver for a 2-digit common-anode seven-segment display.
- Takes an 8-bit value through a load strobe, double-buffers it, and alternates between the two digits at a fixed dwell rate.
- Produces the active-low segment vector `o_digitalTube` and the digit select `o_sel`.
- Sits directly upstream of the debug LED mirror and the board display pins.

Parameters:
- `CLK_HZ`, 100_000_000: input clock frequency.
- `REFRESH_HZ`, 1000: per-digit dwell rate.
- `DIV = CLK_HZ/REFRESH_HZ` (localparam): clocks per digit. Must be >= 2; elaboration fails otherwise.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_value`  in  8  value to display; high nibble is the tens/left digit, low nibble the ones/right digit.
- `i_load`  in  1  one-cycle strobe that captures `i_value` into the pending buffer.
- `i_blank_lz`  in  1  when 1, blank the high digit while the displayed high nibble is 0.
- `i_enable`  in  1  when 0, all segments are off; timing continues.
- `o_digitalTube`  out  7  segments, active-low (0 = lit); bit0 = a … bit6 = g.
- `o_sel`  out  1  digit select: 0 = low nibble digit, 1 = high nibble digit.
- `o_pending`  out  1  a loaded value is waiting for the next frame boundary.
- `o_frame_tick`  out  1  one-cycle pulse when a new frame starts (`o_sel` goes 1->0).

Behaviour:
- One clock domain; reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - `o_sel` = 0, `o_digitalTube` = 7'h7F, `o_pending` = 0, `o_frame_tick` = 0.
  - Display register = 8'h00, pending register = 8'h00, prescaler = 0.
  - First cycle after reset release: `o_digitalTube` = decode(0) = 7'h40 (if `i_enable` = 1).
- Prescaler:
  - Counts 0..DIV-1. `tick` is asserted when count == DIV-1; count then wraps to 0.
  - Each digit dwells exactly DIV cycles; a full frame is 2*DIV cycles.
- On tick:
  - `o_sel` <= ~`o_sel`.
  - `o_digitalTube` is computed from the new sel and the new display value in the same edge, so there is no one-cycle ghosting.
- Frame boundary (tick while `o_sel` = 1):
  - `o_frame_tick` <= 1 for one cycle.
  - If `o_pending` = 1, display <= pending and `o_pending` <= 0.
  - If `i_load` = 1 in that same cycle, `i_value` is committed directly to display and `o_pending` stays 0.
- Load outside a boundary: pending <= `i_value`, `o_pending` <= 1. Repeated loads overwrite; last load wins. The display never changes mid-frame, so there is no tearing.
- Segment value, in priority order:
  - `i_enable` = 0 -> 7'h7F.
  - Else `o_sel` = 1, `i_blank_lz` = 1 and display[7:4] == 0 -> 7'h7F.
  - Else decode(selected nibble).
- `i_enable` and `i_blank_lz` are sampled every cycle; a change takes effect on `o_digitalTube` at the next clock edge.
- Decode table, hex 0..F -> active-low segments:
  - 0:40, 1:79, 2:24, 3:30
  - 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03
  - C:46, d:21, E:06, F:0E
- Reset asserted mid-frame: on the next edge every register takes its reset value. Any pending value is discarded.

Decomposition:
- Shared package `seven_seg_pkg`:
  - `SEG_OFF` = 7'h7F.
  - Segment bit-index constants A..G.
  - Function `hex_to_seg(nibble) -> [6:0]` holding the table above.
- One combinational sub-module `hex_to_7seg` wrapping that function. It is instantiated once, fed from a mux on the next sel value.

Test Plan (`CLK_HZ` = 4000, `REFRESH_HZ` = 1000, so DIV = 4):
- Reset, then release with `i_enable` = 1:
  - `o_sel` = 0 for 4 cycles, then 1 for 4 cycles, alternating.
  - `o_digitalTube` = 7'h40 throughout.
  - `o_frame_tick` pulses every 8 cycles.
- `i_load` with `i_value` = 8'h3A mid-frame:
  - `o_pending` = 1 until the next boundary.
  - Then sel=0 shows 7'h08 and sel=1 shows 7'h30.
  - `o_pending` returns to 0.
- Loads 8'h12 then 8'h7F in the same frame: only 8'h7F is displayed (sel=0 -> 7'h0E, sel=1 -> 7'h78).
- `i_load` with 8'h55 in the exact boundary cycle: 8'h55 is displayed from that edge (7'h12 on both digits) and `o_pending` stays 0.
- Value 8'h05 with `i_blank_lz` = 1:
  - sel=1 gives 7'h7F; sel=0 gives 7'h12.
  - With `i_blank_lz` = 0, sel=1 gives 7'h40.
- `i_enable` = 0, then reset mid-frame with a value pending:
  - While `i_enable` = 0, `o_digitalTube` = 7'h7F and `o_sel` keeps toggling.
  - After the reset edge, all reset values hold and the pending value is lost.
